// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - op-code constants and decode helpers for the multiply/divide unit
package muldiv_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_signfix.sv
// rtl/muldiv_unit_signfix.sv - conditional two's-complement negation, either one 2*WIDTH word or two WIDTH halves
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] din,
  input  logic               wide,
  input  logic               neg_hi,
  input  logic               neg_lo,
  output logic [2*WIDTH-1:0] dout
);

  logic [2*WIDTH-1:0] din_neg;
  logic [WIDTH-1:0]   hi_neg;
  logic [WIDTH-1:0]   lo_neg;

  assign din_neg = -din;
  assign hi_neg  = -din[2*WIDTH-1:WIDTH];
  assign lo_neg  = -din[WIDTH-1:0];

  // wide negates the whole product; split mode negates each half independently
  always_comb begin
    dout = din;
    if (wide) begin
      if (neg_hi) dout = din_neg;
    end else begin
      if (neg_hi) dout[2*WIDTH-1:WIDTH] = hi_neg;
      if (neg_lo) dout[WIDTH-1:0]       = lo_neg;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider owning HI and LO
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               neg_hi_q, neg_hi_d;
  logic               neg_lo_q, neg_lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   rs_q, rs_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic               in_signed;
  logic               rs_neg;
  logic               rt_neg;
  logic [2*WIDTH-1:0] in_abs;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;

  assign in_signed = md_is_signed(op);
  assign rs_neg    = in_signed & rs_data[WIDTH-1];
  assign rt_neg    = in_signed & rt_data[WIDTH-1];

  muldiv_signfix #(.WIDTH(WIDTH)) u_in_abs (
    .din    ({rs_data, rt_data}),
    .wide   (1'b0),
    .neg_hi (rs_neg),
    .neg_lo (rt_neg),
    .dout   (in_abs)
  );

  assign rs_abs = in_abs[2*WIDTH-1:WIDTH];
  assign rt_abs = in_abs[WIDTH-1:0];

  // accumulator layout: multiply {partial_hi, remaining multiplier}; divide {remainder, dividend/quotient}
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] res;
  logic               div_by_zero;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, dvsr_q};
  assign div_ok    = ~div_trial[WIDTH];
  assign div_next  = {div_ok ? div_trial[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], div_ok};
  assign step      = div_q ? div_next : mul_next;

  muldiv_signfix #(.WIDTH(WIDTH)) u_out_fix (
    .din    (step),
    .wide   (~div_q),
    .neg_hi (neg_hi_q),
    .neg_lo (neg_lo_q),
    .dout   (res)
  );

  // divide by zero reports the raw dividend, not its sign-corrected magnitude
  assign div_by_zero = div_q && (dvsr_q == '0);
  assign fin_hi      = div_by_zero ? rs_q : res[2*WIDTH-1:WIDTH];
  assign fin_lo      = div_by_zero ? {WIDTH{1'b1}} : res[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    mcand_d  = mcand_q;
    dvsr_d   = dvsr_q;
    rs_d     = rs_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    case (state_q)
      S_RUN: begin
        acc_d = step;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = S_DONE;
          hi_d    = fin_hi;
          lo_d    = fin_lo;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          div_d    = md_is_div(op);
          neg_lo_d = rs_neg ^ rt_neg;
          neg_hi_d = md_is_div(op) ? rs_neg : (rs_neg ^ rt_neg);
          mcand_d  = rs_abs;
          dvsr_d   = rt_abs;
          rs_d     = rs_data;
          acc_d    = md_is_div(op) ? {{WIDTH{1'b0}}, rs_abs} : {{WIDTH{1'b0}}, rt_abs};
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      mcand_q  <= '0;
      dvsr_q   <= '0;
      rs_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
      mcand_q  <= mcand_d;
      dvsr_q   <= dvsr_d;
      rs_q     <= rs_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op      = o;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_busy);
    int n;
    int overlap;
    n       = 0;
    overlap = 0;
    while (busy && n < 100) begin
      if (done) overlap++;
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, W'(n), W'(exp_busy));
    check({tag, " busy_done_overlap"}, W'(overlap), '0);
    check({tag, " done"}, {31'b0, done}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    issue(o, a, b);
    wait_done(tag, 32);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    @(negedge clk);
    check({tag, " done_single"}, {31'b0, done}, '0);
  endtask

  initial begin
    int dones;
    int busies;
    rst     = 1'b1;
    start   = 1'b0;
    op      = MD_MULT;
    rs_data = '0;
    rt_data = '0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    wdata   = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, busy}, '0);
    check("reset done", {31'b0, done}, '0);
    check("reset hi", hi, '0);
    check("reset lo", lo, '0);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", MD_DIVU,  32'h0000_0064, 32'd0,        32'h0000_0064, 32'hFFFF_FFFF);
    run_op("div_zero",  MD_DIV,   32'hFFFF_FF9C, 32'd0,        32'hFFFF_FF9C, 32'hFFFF_FFFF);
    run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_rem",  MD_DIVU,  32'd100,       32'd7,        32'd2,         32'd14);

    // second start and an MTLO during RUN must both be dropped
    issue(MD_MULTU, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    op      = MD_DIVU;
    rs_data = 32'd100;
    rt_data = 32'd3;
    start   = 1'b1;
    lo_we   = 1'b1;
    wdata   = 32'h0000_1234;
    @(negedge clk);
    start   = 1'b0;
    lo_we   = 1'b0;
    wait_done("ignore", 26);
    check("ignore hi", hi, 32'd0);
    check("ignore lo", lo, 32'd42);
    @(negedge clk);
    check("ignore no_queue busy", {31'b0, busy}, '0);

    lo_we = 1'b1;
    wdata = 32'h0000_1234;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo lo", lo, 32'h0000_1234);
    check("mtlo hi_kept", hi, 32'd0);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h0000_A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mthilo hi", hi, 32'h0000_A5A5);
    check("mthilo lo", lo, 32'h0000_A5A5);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", {31'b0, busy}, '0);
    check("midrst hi", hi, '0);
    check("midrst lo", lo, '0);
    @(negedge clk);
    rst    = 1'b0;
    dones  = 0;
    busies = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busies++;
    end
    check("midrst no_done", W'(dones), '0);
    check("midrst no_busy", W'(busies), '0);

    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done("b2b first", 32);
    check("b2b first hi", hi, 32'hFFFF_FFFF);
    check("b2b first lo", lo, 32'hFFFF_FFEB);
    issue(MD_DIVU, 32'd100, 32'd7);
    check("b2b no_bubble", {31'b0, busy}, 32'd1);
    wait_done("b2b second", 32);
    check("b2b second hi", hi, 32'd2);
    check("b2b second lo", lo, 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
